vpu_reduce_ctrl: RTL and testbench
==================================

// Module: vpu_reduce_ctrl
// PURPOSE
//  Sequences a multi-chunk dot-product reduction through the pipelined VPU adder tree.
//  Accepts a command giving N chunks of VLEN bits each, streams the chunks into the tree and
//  tracks in-flight sums with a valid pipe (the tree carries no valid signal).
//  Accumulates the SEW-bit tree outputs and returns one SEW-bit result per command.
//  Sits between the tile-row operand buffer and the result writeback in the matmul path.
// PARAMETERS
//  VLEN    `VLEN                 vector width in bits, fed to the tree per chunk
//  SEW     `SEW                  element width; also the width of the accumulator and result
//  LEN_W   8                     width of the chunk-count field; up to 2^LEN_W-1 chunks
//  LANES   VLEN/SEW (local)      elements per chunk; must be a power of two, >= 2
//  STAGES  $clog2(LANES) (local) latency of the tree in cycles
// PORTS
//  clk        in   1      single clock
//  rst_n      in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command request
//  cmd_ready  out  1      high only in IDLE
//  cmd_len    in   LEN_W  number of chunks to reduce (0 allowed)
//  in_valid   in   1      chunk data valid
//  in_ready   out  1      high only in ISSUE
//  in_data    in   VLEN   chunk; element i at [i*SEW +: SEW]
//  res_valid  out  1      result valid; high only in DONE
//  res_ready  in   1      result accepted
//  res_data   out  SEW    accumulated sum, modulo 2^SEW
//  busy       out  1      high whenever state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, cnt=0, acc=0, vld_sr=0, res_data=0,
//   res_valid=0, in_ready=0, cmd_ready=1 from the first cycle after release.
//   Tree sync reset is tied to ~rst_n.
//  States:
//   IDLE   On cmd_valid: acc<=0 and cnt<=cmd_len. Go to DONE if cmd_len==0, otherwise ISSUE.
//   ISSUE  Each in_valid&in_ready: drive in_data into the tree, shift 1 into vld_sr, cnt--.
//          A cycle without a handshake shifts 0 (a bubble).
//          The handshake with cnt==1 moves to DRAIN.
//   DRAIN  in_ready=0. vld_sr keeps shifting in 0.
//          Go to DONE in the cycle vld_sr==0, after any final add has been registered.
//   DONE   res_valid=1 and res_data=acc. On res_ready go to IDLE. res_data is held until the next
//          command is accepted.
//  Valid pipe: vld_sr is STAGES bits deep. vld_sr[STAGES-1] means tree_out is valid this cycle.
//   In that case acc<=acc+tree_out at the end of the cycle (SEW-bit, wraps, no saturation).
//  Timing: cycle 0 = chunk handshake. The chunk's lane sum is valid in cycle STAGES.
//   acc includes it from cycle STAGES+1.
//   For a command, res_valid first rises in cycle last_handshake+STAGES+1.
//  Tree datapath never stalls. Backpressure applies only at in_ready and at DONE, so no
//   in-flight sum is ever dropped.
//  One command in flight. cmd_ready=0 from acceptance until the result handshake completes.
//  in_data outside ISSUE is ignored; tree input is driven to 0 when no handshake occurs.
//  Reset mid-operation: all state is cleared immediately and any partial sum is discarded.
// STRUCTURE
//  Shared package vpu_pkg: LANES, STAGES, the state enum {IDLE,ISSUE,DRAIN,DONE} and LEN_W.
//  One sub-module: a vpu_addertree instance (clk, rst=~rst_n, in_flat, out).
//  FSM, counter, valid pipe and accumulator live in this module.
// TESTING  (VLEN=128, SEW=32 -> LANES=4, STAGES=2)
//  1. len=1, lanes {1,2,3,4} -> res_data=10, res_valid in cycle 3 after the handshake.
//  2. len=3, back-to-back chunks of all lanes 1 -> res_data=12, res_valid 5 cycles after the
//     first handshake.
//  3. len=2, all lanes 0xFFFFFFFF -> res_data=0xFFFFFFF8 (wraps).
//  4. len=0 -> res_valid next cycle, res_data=0, no in_ready pulse.
//  5. len=4 with in_valid bubbles (1,0,0,1,1,0,1), lanes {i,i,i,i} for chunk i=1..4
//     -> res_data=40.
//  6. res_ready low 5 cycles in DONE -> res_data stable, cmd_ready=0, in_ready=0.
//     rst_n pulse mid-ISSUE -> res_valid=0, busy=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared constants and FSM state encoding for the VPU reduction path.
//   VLEN   : chunk width in bits fed to the adder tree
//   SEW    : element / accumulator / result width
//   LEN_W  : width of the chunk-count field
//   LANES  : elements per chunk (power of two, >= 2)
//   STAGES : adder tree latency in cycles
package vpu_pkg;

    localparam int unsigned VLEN   = 128;
    localparam int unsigned SEW    = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned LANES  = VLEN / SEW;
    localparam int unsigned STAGES = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/vpu_addertree.sv
// Pipelined binary adder tree: sums LANES SEW-bit elements, one register per level.
// Latency is $clog2(LANES) cycles; carries no valid signal and never stalls.
//   clk     : clock
//   rst     : synchronous active-high reset, clears all pipeline registers
//   in_flat : LANES elements, element i at [i*SEW +: SEW]
//   out     : lane sum of the input presented STAGES cycles earlier (wraps mod 2^SEW)
module vpu_addertree #(
    parameter int unsigned LANES = 4,
    parameter int unsigned SEW   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*SEW-1:0]   in_flat,
    output logic [SEW-1:0]         out
);

    // Heap-indexed nodes: node n sums children 2n and 2n+1; indices >= LANES are the inputs.
    logic [SEW-1:0] node_q [1:LANES-1];

    for (genvar n = 1; n < LANES; n++) begin : g_node
        logic [SEW-1:0] a;
        logic [SEW-1:0] b;

        if (2 * n >= LANES) begin : g_leaf
            assign a = in_flat[(2*n   - LANES)*SEW +: SEW];
            assign b = in_flat[(2*n+1 - LANES)*SEW +: SEW];
        end else begin : g_int
            assign a = node_q[2*n];
            assign b = node_q[2*n+1];
        end

        always_ff @(posedge clk) begin
            if (rst) node_q[n] <= '0;
            else     node_q[n] <= a + b;
        end
    end

    assign out = node_q[1];

endmodule

// File: rtl/vpu_reduce_ctrl.sv
// Sequences a multi-chunk dot-product reduction through the pipelined adder tree and
// accumulates the tree outputs into one SEW-bit result per command.
//   cmd_valid/cmd_ready/cmd_len : command handshake, cmd_len chunks (0 allowed)
//   in_valid/in_ready/in_data   : chunk stream, accepted only while issuing
//   res_valid/res_ready/res_data: result handshake, res_data held until the next command
//   busy                        : high whenever the controller is not idle
module vpu_reduce_ctrl
    import vpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VLEN-1:0]   in_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SEW-1:0]    res_data,
    output logic              busy
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [SEW-1:0]     acc_q, acc_d;
    logic [SEW-1:0]     res_q, res_d;
    logic [STAGES-1:0]  vld_q, vld_d;
    logic               cmd_ready_q, in_ready_q, res_valid_q, busy_q;

    logic               hs;
    logic [VLEN-1:0]    tree_in;
    logic [SEW-1:0]     tree_out;

    vpu_addertree #(
        .LANES (LANES),
        .SEW   (SEW)
    ) u_tree (
        .clk     (clk),
        .rst     (~rst_n),
        .in_flat (tree_in),
        .out     (tree_out)
    );

    // Next-state, counter, valid pipe and accumulator.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;

        // in_ready_q is high exactly in ISSUE, so hs only occurs there.
        hs      = in_valid & in_ready_q;
        tree_in = hs ? in_data : '0;
        vld_d   = STAGES'({vld_q, hs});

        if (vld_q[STAGES-1]) acc_d = acc_q + tree_out;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    acc_d   = '0;
                    cnt_d   = cmd_len;
                    state_d = (cmd_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (hs) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the pipe empties; the final add lands in the same edge.
                if (vld_d == '0) state_d = DONE;
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == DONE && state_q != DONE) res_d = acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            vld_q       <= '0;
            cmd_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            vld_q       <= vld_d;
            cmd_ready_q <= (state_d == IDLE);
            in_ready_q  <= (state_d == ISSUE);
            res_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vpu_reduce_ctrl.sv
// Directed bench for vpu_reduce_ctrl (VLEN=128, SEW=32, LANES=4, STAGES=2).
module tb_vpu_reduce_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_len;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_data;
    logic         busy;

    int errors = 0;
    int checks = 0;

    vpu_reduce_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
        cmd_len   = '0;
    endtask

    task automatic send_chunk(input string tag, input logic [127:0] d);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic accept_result(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_res_valid_clr"}, 32'(res_valid), 32'd0);
        chk({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    function automatic logic [127:0] splat(input logic [31:0] v);
        return {v, v, v, v};
    endfunction

    initial begin
        logic [6:0] pat;
        int         k;
        int         n;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b0;

        tick();
        tick();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_res_data",  res_data,       32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // 1: single chunk {1,2,3,4}, result in cycle 3 after handshake.
        send_cmd(8'd1);
        chk("t1_busy",      32'(busy),      32'd1);
        chk("t1_cmd_ready", 32'(cmd_ready), 32'd0);
        send_chunk("t1", {32'd4, 32'd3, 32'd2, 32'd1});
        chk("t1_in_ready_off", 32'(in_ready), 32'd0);
        chk("t1_rv_c1", 32'(res_valid), 32'd0);
        tick();
        chk("t1_rv_c2", 32'(res_valid), 32'd0);
        tick();
        chk("t1_rv_c3", 32'(res_valid), 32'd1);
        chk("t1_data",  res_data,       32'd10);
        accept_result("t1");
        chk("t1_data_held", res_data, 32'd10);

        // 2: three back-to-back chunks of ones, result 5 cycles after first handshake.
        send_cmd(8'd3);
        send_chunk("t2a", splat(32'd1));
        send_chunk("t2b", splat(32'd1));
        send_chunk("t2c", splat(32'd1));
        chk("t2_rv_c3", 32'(res_valid), 32'd0);
        tick();
        chk("t2_rv_c4", 32'(res_valid), 32'd0);
        tick();
        chk("t2_rv_c5", 32'(res_valid), 32'd1);
        chk("t2_data",  res_data,       32'd12);
        accept_result("t2");

        // 3: accumulator wraps modulo 2^32.
        send_cmd(8'd2);
        send_chunk("t3a", splat(32'hFFFF_FFFF));
        send_chunk("t3b", splat(32'hFFFF_FFFF));
        tick();
        tick();
        chk("t3_rv",   32'(res_valid), 32'd1);
        chk("t3_data", res_data,       32'hFFFF_FFF8);
        accept_result("t3");

        // 4: zero-length command goes straight to a zero result.
        send_cmd(8'd0);
        chk("t4_rv",       32'(res_valid), 32'd1);
        chk("t4_in_ready", 32'(in_ready),  32'd0);
        chk("t4_data",     res_data,       32'd0);
        chk("t4_busy",     32'(busy),      32'd1);
        accept_result("t4");

        // 5: four chunks with bubbles; junk on in_data during bubbles must be ignored.
        send_cmd(8'd4);
        pat = 7'b1011001; // bit 0 first: 1,0,0,1,1,0,1
        k   = 1;
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            in_data  = pat[i] ? splat(32'(k)) : splat(32'hDEAD_BEEF);
            if (pat[i]) k++;
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk("t5_chunks_sent", 32'(k), 32'd5);
        n = 1;
        while (res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t5_latency", 32'(n), 32'd3);
        chk("t5_data",    res_data, 32'd40);

        // 6: result backpressure; a command presented meanwhile must be ignored.
        cmd_valid = 1'b1;
        cmd_len   = 8'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_hold_rv",   32'(res_valid), 32'd1);
            chk("t6_hold_data", res_data,       32'd40);
            chk("t6_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("t6_in_ready",  32'(in_ready),  32'd0);
        end
        cmd_valid = 1'b0;
        cmd_len   = '0;
        accept_result("t6");

        // 6b: reset in the middle of ISSUE discards everything.
        send_cmd(8'd3);
        send_chunk("t6r", splat(32'd7));
        rst_n = 1'b0;
        #1;
        chk("t6r_busy",     32'(busy),      32'd0);
        chk("t6r_rv",       32'(res_valid), 32'd0);
        chk("t6r_in_ready", 32'(in_ready),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6r_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t6r_busy_idle", 32'(busy),      32'd0);
        send_cmd(8'd1);
        send_chunk("t6r_new", splat(32'd1));
        tick();
        tick();
        chk("t6r_new_rv",   32'(res_valid), 32'd1);
        chk("t6r_new_data", res_data,       32'd4);
        accept_result("t6r_new");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
